// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with prescaled step enable, wrap/saturate modes,
// clamped parallel load and registered tick/wrap pulses.
module updown_counter_gen #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DIV     = 50000000,
  parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             at_limit
);

  localparam int unsigned     PreW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(DIV - 1);
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      // Load clamps so count can never exceed MaxVal; that lets the step logic use equality.
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
      pre_d   = '0;
    end else if (en) begin
      if (pre_q == PreLast) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (up_down) begin
          if (count_q != MaxVal) begin
            count_d = count_q + 1'b1;
          end else if (!mode) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end else if (!mode) begin
            count_d = MaxVal;
            wrap_d  = 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count    = count_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign at_limit = (up_down && (count_q == MaxVal)) || (!up_down && (count_q == '0));

endmodule
